// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the byte-addressed memory block.
// Extends sub-word loads and performs read-modify-write for SB/SH.
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memRead,
   output logic        mem_memWrite,
   input  logic [31:0] mem_memData
);

   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP, ERR} stateT;

   stateT       state;
   logic        curWrite;
   logic [2:0]  curFunct3;
   logic [15:0] curWdata;
   logic        memReadQ;
   logic        memWriteQ;
   logic        reqLegal;
   logic        reqInRange;
   logic [31:0] loadValue;
   logic [31:0] mergedWord;

   always_comb begin
      reqLegal = 1'b0;
      if (req_write)
         reqLegal = (req_funct3 inside {3'b000, 3'b001, 3'b010});
      else
         reqLegal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   end

   // 33-bit sum so addresses near the top of the 32-bit space cannot wrap into range.
   assign reqInRange = ({1'b0, req_addr} + 33'd3) <= 33'(MEM_BYTES - 1);

   always_comb begin
      loadValue = mem_memData;
      case (curFunct3)
         3'b000:  loadValue = {{24{mem_memData[7]}}, mem_memData[7:0]};
         3'b001:  loadValue = {{16{mem_memData[15]}}, mem_memData[15:0]};
         3'b100:  loadValue = {24'h000000, mem_memData[7:0]};
         3'b101:  loadValue = {16'h0000, mem_memData[15:0]};
         default: loadValue = mem_memData;
      endcase
   end

   assign mergedWord = (curFunct3 == 3'b000) ? {mem_memData[31:8], curWdata[7:0]}
                                             : {mem_memData[31:16], curWdata};

   // Merge happens on the CAPTURE exit edge straight into the write-data register,
   // and ERR doubles as the response cycle, which keeps SB/SH at 4 and errors at 1 cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_rdata    <= '0;
         mem_address   <= '0;
         mem_writeData <= '0;
         memReadQ      <= 1'b0;
         memWriteQ     <= 1'b0;
         curWrite      <= 1'b0;
         curFunct3     <= '0;
         curWdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  curWrite  <= req_write;
                  curFunct3 <= req_funct3;
                  curWdata  <= req_wdata[15:0];
                  if (!reqLegal || !reqInRange) begin
                     state      <= ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_write && req_funct3 == 3'b010) begin
                     state         <= WRITE;
                     memWriteQ     <= 1'b1;
                     mem_address   <= req_addr;
                     mem_writeData <= req_wdata;
                  end else begin
                     state       <= READ;
                     memReadQ    <= 1'b1;
                     mem_address <= req_addr;
                  end
               end
            end
            READ: state <= CAPTURE;
            CAPTURE: begin
               memReadQ <= 1'b0;
               if (curWrite) begin
                  state         <= WRITE;
                  memWriteQ     <= 1'b1;
                  mem_writeData <= mergedWord;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= loadValue;
               end
            end
            WRITE: begin
               memWriteQ  <= 1'b0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP, ERR: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign mem_memRead  = memReadQ & ~reset;
   assign mem_memWrite = memWriteQ & ~reset;

endmodule
